dram_ctrl: RTL and testbench

- Request/response front-end between the processor control unit and the single-port data memory (dram).
- Accepts one load or store per handshake and drives the memory's addr, write_en, read_en and Data_in from registers.
- Captures the memory's one-cycle-latency read data and returns it with a valid/ready response.
- Rejects out-of-range addresses without touching memory, because the 9-bit address bus covers more locations than the memory implements.

---
 rtl/dram_pkg.sv | 15 +
 rtl/dram_ctrl.sv | 136 +++++++++++++
 tb/tb_dram_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared parameters and the state encoding for the data-memory front-end.
package dram_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/dram_ctrl.sv
// Request/response front-end for the single-port data memory.
// The controller accepts one load or store at a time. It drives the memory
// strobes from registers, captures the read data one cycle after the read
// edge, and returns a response with a valid/ready handshake. Addresses at or
// above DEPTH are rejected without strobing the memory.
// DEPTH is assumed to be strictly less than 2**ADDR_W.
module dram_ctrl #(
    parameter int ADDR_W = dram_pkg::ADDR_W,
    parameter int DATA_W = dram_pkg::DATA_W,
    parameter int DEPTH  = dram_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import dram_pkg::*;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic              mem_ren_q, mem_ren_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              addr_err;

    assign addr_err = (req_addr >= LIMIT);

    // Next-state and datapath decode for the four-state access sequence.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (addr_err) begin
                        // Out-of-range address: answer immediately, never strobe memory.
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_addr_d  = req_addr;
                        mem_wen_d   = req_we;
                        mem_ren_d   = ~req_we;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // The memory acts on this edge; the registered write strobe
                // still records whether the access is a store.
                if (mem_wen_q) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Read data is valid one cycle after the read edge.
                state_d     = ST_RESP;
                rsp_rdata_d = mem_rdata;
                rsp_err_d   = 1'b0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops the strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Handshake and status outputs decode from state only.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl with a behavioural one-cycle-latency memory.
// Expected responses (data, error flag, cycle of first valid) are queued when a
// request is accepted; a monitor pops and compares when rsp_valid appears.
module tb_dram_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: preloaded on the first edge, then synchronous
    // write, and read data registered on the read edge.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    bit                loaded;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[1]  <= 16'd80;
            mem[2]  <= 16'd50;
            mem[3]  <= 16'h0033;
            mem[31] <= 16'h7777;
            mem_rdata <= '0;
            loaded <= 1'b1;
        end else begin
            if (mem_wen && mem_addr < 9'd32) mem[mem_addr[4:0]] <= mem_wdata;
            if (mem_ren && mem_addr < 9'd32) mem_rdata <= mem[mem_addr[4:0]];
        end
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    // Monitor: compare each new response, then check it stays stable while stalled.
    int                wen_cnt;
    int                ren_cnt;
    bit                in_rsp;
    exp_t              cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else begin
            if (mem_wen) wen_cnt++;
            if (mem_ren) ren_cnt++;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        cur = sb.pop_front();
                        check("rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
                        check("rsp_err", 32'(rsp_err), 32'(cur.err));
                        check("rsp_cycle", 32'(cyc), 32'(cur.cyc));
                    end
                    in_rsp = 1'b1;
                end else begin
                    check("rsp_rdata_stable", 32'(rsp_rdata), 32'(cur.rdata));
                    check("rsp_err_stable", 32'(rsp_err), 32'(cur.err));
                end
                if (rsp_ready) in_rsp = 1'b0;
            end
        end
    end

    // Present a request and hold it until accepted; called and returns at posedge+1.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                         input logic exp_err, input int lat, output int acc);
        int waited;
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            acc = -1;
        end else begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + 1 + lat;
            sb.push_back(e);
            acc = cyc + 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || busy) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_timeout", 32'(waited < 100), 32'd1);
    endtask

    int acc0, acc1, acc2;
    int w0, r0;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Load addr 1 -> 80, one read strobe.
        r0 = ren_cnt;
        issue(1'b0, 9'd1, 16'h0, 16'd80, 1'b0, 2, acc0);
        check("load1_busy", 32'(busy), 32'd1);
        drain();
        check("load1_ren_pulses", 32'(ren_cnt - r0), 32'd1);

        // Store 0x1234 to addr 5 then load it back.
        w0 = wen_cnt;
        issue(1'b1, 9'd5, 16'h1234, 16'h0, 1'b0, 1, acc0);
        drain();
        check("store5_wen_pulses", 32'(wen_cnt - w0), 32'd1);
        issue(1'b0, 9'd5, 16'h0, 16'h1234, 1'b0, 2, acc0);
        drain();

        // Out-of-range addresses, then the highest valid address.
        w0 = wen_cnt;
        r0 = ren_cnt;
        issue(1'b0, 9'd32, 16'h0, 16'h0, 1'b1, 0, acc0);
        issue(1'b1, 9'd511, 16'hFFFF, 16'h0, 1'b1, 0, acc0);
        drain();
        check("err_no_strobes", 32'((wen_cnt - w0) + (ren_cnt - r0)), 32'd0);
        issue(1'b0, 9'd31, 16'h0, 16'h7777, 1'b0, 2, acc0);
        drain();

        // Stalled response with a second request waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 9'd2, 16'h0, 16'd50, 1'b0, 2, acc0);
        for (int i = 0; i < 10 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'd1;
        r0 = ren_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_rdata", 32'(rsp_rdata), 32'd50);
        end
        check("stall_no_access", 32'(ren_cnt - r0), 32'd0);
        rsp_ready = 1'b1;
        issue(1'b0, 9'd1, 16'h0, 16'd80, 1'b0, 2, acc0);
        drain();

        // Reset during a store's ACCESS cycle: store is dropped.
        issue(1'b1, 9'd3, 16'hBEEF, 16'h0, 1'b0, 1, acc0);
        check("rst_mid_wen_before", 32'(mem_wen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wen_drop", 32'(mem_wen), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 9'd3, 16'h0, 16'h0033, 1'b0, 2, acc0);
        drain();

        // Back-to-back: store 7=9, load 7, load 1.
        issue(1'b1, 9'd7, 16'd9, 16'h0, 1'b0, 1, acc0);
        issue(1'b0, 9'd7, 16'h0, 16'd9, 1'b0, 2, acc1);
        issue(1'b0, 9'd1, 16'h0, 16'd80, 1'b0, 2, acc2);
        drain();
        check("b2b_store_gap", 32'(acc1 - acc0), 32'd3);
        check("b2b_load_gap", 32'(acc2 - acc1), 32'd4);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
